// File: rtl/comptest_pkg.sv
// Shared types for the comparator-test mux scan sequencer.
package comptest_pkg;

  localparam int unsigned ADR_W_DEF = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLoad,
    StSettle,
    StArm,
    StFire,
    StNext
  } state_e;

endpackage

// File: rtl/adr_gen.sv
// Combinational address generator: high channel plus med/low offsets, wrapping mod 2**ADR_W.
module adr_gen
  import comptest_pkg::*;
#(
  parameter int unsigned ADR_W = ADR_W_DEF
) (
  input  logic [ADR_W-1:0] i_ch,
  input  logic [ADR_W-1:0] i_med_off,
  input  logic [ADR_W-1:0] i_low_off,
  output logic [ADR_W-1:0] o_high,
  output logic [ADR_W-1:0] o_med,
  output logic [ADR_W-1:0] o_low
);

  assign o_high = i_ch;
  assign o_med  = i_ch + i_med_off;
  assign o_low  = i_ch + i_low_off;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps high/med/low pulse-mux addresses across a channel range, settling and firing pulses
// per channel; refuses to enable the mux on overlapping addresses.
module mux_scan_sequencer
  import comptest_pkg::*;
#(
  parameter int unsigned ADR_W    = ADR_W_DEF,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned REPS_W   = 8,
  parameter int unsigned ACK_TO   = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADR_W-1:0]    first_ch,
  input  logic [ADR_W-1:0]    last_ch,
  input  logic [ADR_W-1:0]    med_offset,
  input  logic [ADR_W-1:0]    low_offset,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [REPS_W-1:0]   num_pulses,
  input  logic                pulse_ack,
  output logic [ADR_W-1:0]    high_adr,
  output logic [ADR_W-1:0]    med_adr,
  output logic [ADR_W-1:0]    low_adr,
  output logic                mux_en,
  output logic                pulse_req,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned TO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  state_e              r_state, w_state_d;
  logic [ADR_W-1:0]    r_ch, w_ch_d;
  logic [ADR_W-1:0]    r_last, r_med_off, r_low_off;
  logic [SETTLE_W-1:0] r_settle;
  logic [REPS_W-1:0]   r_pulses;
  logic [SETTLE_W-1:0] r_cnt, w_cnt_d;
  logic [REPS_W-1:0]   r_reps, w_reps_d;
  logic [TO_W-1:0]     r_to_cnt, w_to_d;
  logic [ADR_W-1:0]    r_high, r_med, r_low;
  logic [ADR_W-1:0]    w_high, w_med, w_low;
  logic                r_mux_en, w_mux_en_d;
  logic                r_pulse_req, w_pulse_req_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;
  logic                w_capture, w_load, w_ack;

  adr_gen #(
    .ADR_W(ADR_W)
  ) u_adr_gen (
    .i_ch     (r_ch),
    .i_med_off(r_med_off),
    .i_low_off(r_low_off),
    .o_high   (w_high),
    .o_med    (w_med),
    .o_low    (w_low)
  );

  // An ack only counts while a request is actually outstanding.
  assign w_ack = (r_state == StFire) && r_pulse_req && pulse_ack;

  always_comb begin
    w_state_d = r_state;
    w_ch_d    = r_ch;
    w_cnt_d   = r_cnt;
    w_reps_d  = r_reps;
    w_to_d    = r_to_cnt;
    w_err_d   = r_err;
    w_done_d  = 1'b0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    if (abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_capture = 1'b1;
            w_err_d   = 1'b0;
            w_ch_d    = first_ch;
            w_state_d = StCheck;
          end
        end
        StCheck: begin
          if ((r_med_off == '0) || (r_low_off == '0) || (r_med_off == r_low_off)) begin
            w_err_d   = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_state_d = StLoad;
          end
        end
        StLoad: begin
          w_load    = 1'b1;
          w_cnt_d   = r_settle;
          w_state_d = StSettle;
        end
        StSettle: begin
          // Treating 0 like 1 guarantees at least one settle cycle.
          w_cnt_d = r_cnt - 1'b1;
          if (r_cnt <= SETTLE_W'(1)) w_state_d = StArm;
        end
        StArm: begin
          w_reps_d  = r_pulses;
          w_to_d    = '0;
          w_state_d = (r_pulses == '0) ? StNext : StFire;
        end
        StFire: begin
          if (w_ack) begin
            w_reps_d = r_reps - 1'b1;
            w_to_d   = '0;
            if (r_reps == REPS_W'(1)) w_state_d = StNext;
          end else if (r_pulse_req) begin
            if (r_to_cnt == TO_W'(ACK_TO - 1)) begin
              w_err_d   = 1'b1;
              w_state_d = StIdle;
            end else begin
              w_to_d = r_to_cnt + 1'b1;
            end
          end
        end
        StNext: begin
          if (r_ch == r_last) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_ch_d    = r_ch + 1'b1;
            w_state_d = StLoad;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
    w_mux_en_d    = (w_state_d == StArm) || (w_state_d == StFire);
    // Request drops for one cycle after each accepted ack, then re-asserts.
    w_pulse_req_d = (w_state_d == StFire) && !w_ack;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_ch        <= '0;
      r_last      <= '0;
      r_med_off   <= '0;
      r_low_off   <= '0;
      r_settle    <= '0;
      r_pulses    <= '0;
      r_cnt       <= '0;
      r_reps      <= '0;
      r_to_cnt    <= '0;
      r_high      <= '0;
      r_med       <= '0;
      r_low       <= '0;
      r_mux_en    <= 1'b0;
      r_pulse_req <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ch        <= w_ch_d;
      r_cnt       <= w_cnt_d;
      r_reps      <= w_reps_d;
      r_to_cnt    <= w_to_d;
      r_mux_en    <= w_mux_en_d;
      r_pulse_req <= w_pulse_req_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      if (w_capture) begin
        r_last    <= last_ch;
        r_med_off <= med_offset;
        r_low_off <= low_offset;
        r_settle  <= settle_cycles;
        r_pulses  <= num_pulses;
      end
      if (w_load) begin
        r_high <= w_high;
        r_med  <= w_med;
        r_low  <= w_low;
      end
    end
  end

  assign high_adr  = r_high;
  assign med_adr   = r_med;
  assign low_adr   = r_low;
  assign mux_en    = r_mux_en;
  assign pulse_req = r_pulse_req;
  assign busy      = (r_state != StIdle);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed scenarios plus randomized scans checked against
// an arithmetic model of the expected channel/address sequence.
module tb_mux_scan_sequencer;

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned ACK_TO = 255;
  localparam int          CH     = 1 << ADR_W;
  localparam int          BUDGET = 20000;

  logic             clock = 1'b0;
  logic             reset_n, start, abort, pulse_ack;
  logic [ADR_W-1:0] first_ch, last_ch, med_offset, low_offset;
  logic [7:0]       settle_cycles, num_pulses;
  logic [ADR_W-1:0] high_adr, med_adr, low_adr;
  logic             mux_en, pulse_req, busy, done, err;

  int checks = 0;
  int errors = 0;

  mux_scan_sequencer #(
    .ADR_W   (ADR_W),
    .SETTLE_W(8),
    .REPS_W  (8),
    .ACK_TO  (ACK_TO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .first_ch     (first_ch),
    .last_ch      (last_ch),
    .med_offset   (med_offset),
    .low_offset   (low_offset),
    .settle_cycles(settle_cycles),
    .num_pulses   (num_pulses),
    .pulse_ack    (pulse_ack),
    .high_adr     (high_adr),
    .med_adr      (med_adr),
    .low_adr      (low_adr),
    .mux_en       (mux_en),
    .pulse_req    (pulse_req),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  // Monitor + pulser: records each mux-enable window, counts acks/done, flags invariant breaks.
  logic [3*ADR_W-1:0] q_tup[$];
  logic [3*ADR_W-1:0] prev_tup;
  logic [3*ADR_W-1:0] cur_tup;
  bit                 prev_mux_en;
  bit                 ack_en = 1'b1;
  bit                 ack_new;
  int                 inv_viol = 0;
  int                 ack_cnt = 0;
  int                 done_cnt = 0;

  assign cur_tup = {high_adr, med_adr, low_adr};

  always @(negedge clock) begin
    if (mux_en === 1'b1) begin
      if (high_adr == med_adr || high_adr == low_adr || med_adr == low_adr) inv_viol++;
      if (prev_mux_en && cur_tup !== prev_tup) inv_viol++;
      if (!prev_mux_en) q_tup.push_back(cur_tup);
    end
    if (pulse_req === 1'b1 && mux_en !== 1'b1) inv_viol++;
    if (done === 1'b1) done_cnt++;
    prev_mux_en = (mux_en === 1'b1);
    prev_tup    = cur_tup;
    if (pulse_req === 1'b1) ack_new = ack_en && ($urandom_range(0, 1) == 1);
    else ack_new = ack_en && (mux_en !== 1'b1) && ($urandom_range(0, 7) == 0);
    pulse_ack = ack_new;
    if (pulse_req === 1'b1 && ack_new) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a scan and follows it until busy drops; config inputs are scrambled after start.
  task automatic run_scan(input int f, input int l, input int mo, input int lo, input int st,
                          input int np, output int lat, output int req_cyc, output bit e2,
                          output bit mux_at_end, output bit to);
    @(negedge clock);
    first_ch      = ADR_W'(f);
    last_ch       = ADR_W'(l);
    med_offset    = ADR_W'(mo);
    low_offset    = ADR_W'(lo);
    settle_cycles = 8'(st);
    num_pulses    = 8'(np);
    start         = 1'b1;
    lat = -1; req_cyc = 0; e2 = 1'b0; mux_at_end = 1'b1; to = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start         = 1'b0;
        first_ch      = ADR_W'($urandom);
        last_ch       = ADR_W'($urandom);
        med_offset    = ADR_W'($urandom);
        low_offset    = ADR_W'($urandom);
        settle_cycles = 8'($urandom);
        num_pulses    = 8'($urandom);
      end
      if (c == 2) e2 = (err === 1'b1);
      if (mux_en === 1'b1 && lat < 0) lat = c;
      if (pulse_req === 1'b1) req_cyc++;
      if (busy !== 1'b1) begin
        mux_at_end = (mux_en === 1'b1);
        to = 1'b0;
        break;
      end
    end
  endtask

  // Reference model: channels first..last (wrapping), offsets added mod 2**ADR_W.
  task automatic score(input string tag, input int f, input int l, input int mo, input int lo,
                       input int np, input int q0, input int a0, input int d0);
    bit conflict;
    int n;
    int ch;
    logic [31:0] exp_t;
    conflict = (mo == 0) || (lo == 0) || (mo == lo);
    n = ((l - f + CH) % CH) + 1;
    if (conflict) begin
      chk({tag, "_windows"}, q_tup.size() - q0, 0);
      chk({tag, "_acks"}, ack_cnt - a0, 0);
      chk({tag, "_done"}, done_cnt - d0, 0);
      chk({tag, "_err"}, err, 1);
    end else begin
      chk({tag, "_windows"}, q_tup.size() - q0, n);
      for (int k = 0; k < n; k++) begin
        ch    = (f + k) % CH;
        exp_t = (ch << (2 * ADR_W)) | (((ch + mo) % CH) << ADR_W) | ((ch + lo) % CH);
        chk($sformatf("%s_adr%0d", tag, k), q_tup[q0+k], exp_t);
      end
      chk({tag, "_acks"}, ack_cnt - a0, n * np);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_err"}, err, 0);
    end
    chk({tag, "_invariant"}, inv_viol, 0);
  endtask

  initial begin
    int  lat, req_cyc, q0, a0, d0, f, l, mo, lo, st, np;
    bit  e2, mux_end, to, found;

    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    first_ch = '0; last_ch = '0; med_offset = '0; low_offset = '0;
    settle_cycles = '0; num_pulses = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_adr", {20'd0, cur_tup}, 0);
    chk("rst_mux_en", mux_en, 0);
    chk("rst_pulse_req", pulse_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Directed: three channels, two pulses each.
    q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
    run_scan(2, 4, 1, 2, 3, 2, lat, req_cyc, e2, mux_end, to);
    chk("t1_timeout", to, 0);
    chk("t1_latency", lat, 6);
    chk("t1_done_at_end", done, 1);
    @(negedge clock);
    score("t1", 2, 4, 1, 2, 2, q0, a0, d0);

    // Equal offsets: conflict error two cycles after start, mux never enabled.
    q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
    run_scan(3, 6, 5, 5, 2, 2, lat, req_cyc, e2, mux_end, to);
    chk("t2_timeout", to, 0);
    chk("t2_err_at_2", e2, 1);
    chk("t2_req_cycles", req_cyc, 0);
    @(negedge clock);
    score("t2", 3, 6, 5, 5, 2, q0, a0, d0);

    // Wrapping range 14..1.
    q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
    run_scan(14, 1, 3, 9, 0, 1, lat, req_cyc, e2, mux_end, to);
    chk("t3_timeout", to, 0);
    chk("t3_latency", lat, 4);
    @(negedge clock);
    score("t3", 14, 1, 3, 9, 1, q0, a0, d0);

    // Full-range wrap: last = first - 1 covers every channel.
    q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
    run_scan(7, 6, 2, 13, 1, 1, lat, req_cyc, e2, mux_end, to);
    chk("t3b_timeout", to, 0);
    @(negedge clock);
    score("t3b", 7, 6, 2, 13, 1, q0, a0, d0);

    // Withheld ack: timeout after ACK_TO request cycles.
    ack_en = 1'b0;
    d0 = done_cnt;
    run_scan(0, 2, 1, 2, 0, 1, lat, req_cyc, e2, mux_end, to);
    chk("t4_timeout", to, 0);
    chk("t4_req_cycles", req_cyc, ACK_TO);
    chk("t4_err", err, 1);
    chk("t4_mux_en_off", mux_end, 0);
    @(negedge clock);
    chk("t4_done", done_cnt - d0, 0);
    chk("t4_invariant", inv_viol, 0);

    // Abort during SETTLE.
    d0 = done_cnt;
    @(negedge clock);
    first_ch = 4'd5; last_ch = 4'd9; med_offset = 4'd3; low_offset = 4'd7;
    settle_cycles = 8'd10; num_pulses = 8'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("t5s_busy_before", busy, 1);
    chk("t5s_mux_before", mux_en, 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t5s_busy", busy, 0);
    chk("t5s_mux_en", mux_en, 0);
    chk("t5s_pulse_req", pulse_req, 0);
    chk("t5s_err", err, 0);
    chk("t5s_adr_hold", {20'd0, cur_tup}, {20'd0, 4'd5, 4'd8, 4'd12});

    // Abort during FIRE, with a simultaneous start that must lose.
    @(negedge clock);
    first_ch = 4'd0; last_ch = 4'd3; med_offset = 4'd1; low_offset = 4'd2;
    settle_cycles = 8'd0; num_pulses = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pulse_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("t5f_fire_reached", found, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    chk("t5f_busy", busy, 0);
    chk("t5f_pulse_req", pulse_req, 0);
    chk("t5f_mux_en", mux_en, 0);
    @(negedge clock);
    chk("t5f_still_idle", busy, 0);
    chk("t5f_no_done", done_cnt - d0, 0);
    ack_en = 1'b1;

    // Fresh start after abort rescans normally.
    q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
    run_scan(0, 3, 1, 2, 2, 2, lat, req_cyc, e2, mux_end, to);
    chk("t5r_timeout", to, 0);
    @(negedge clock);
    score("t5r", 0, 3, 1, 2, 2, q0, a0, d0);

    // Randomized scans.
    for (int it = 0; it < 8; it++) begin
      f  = int'($urandom_range(0, CH - 1));
      l  = int'($urandom_range(0, CH - 1));
      mo = int'($urandom_range(0, CH - 1));
      lo = int'($urandom_range(0, CH - 1));
      st = int'($urandom_range(0, 5));
      np = int'($urandom_range(0, 3));
      q0 = q_tup.size(); a0 = ack_cnt; d0 = done_cnt;
      run_scan(f, l, mo, lo, st, np, lat, req_cyc, e2, mux_end, to);
      chk($sformatf("r%0d_timeout", it), to, 0);
      if (mo != 0 && lo != 0 && mo != lo)
        chk($sformatf("r%0d_latency", it), lat, ((st == 0) ? 1 : st) + 3);
      @(negedge clock);
      score($sformatf("r%0d", it), f, l, mo, lo, np, q0, a0, d0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
